// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter: shares a single-port TCM between the core data port and a
// host (loader / signature readback) port. One access per cycle, combinational
// grant, one-cycle response latency. Contended cycles use a bounded-burst
// round-robin, and h_lock_i hands the memory exclusively to the host.
module tcm_port_arbiter #(
  parameter int AW        = 15,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // core port
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [3:0]    c_be_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [31:0]   c_wdata_i,
  output logic          c_gnt_o,
  output logic          c_rvalid_o,
  output logic [31:0]   c_rdata_o,
  // host port
  input  logic          h_req_i,
  input  logic          h_we_i,
  input  logic [3:0]    h_be_i,
  input  logic [AW-1:0] h_addr_i,
  input  logic [31:0]   h_wdata_i,
  output logic          h_gnt_o,
  output logic          h_rvalid_o,
  output logic [31:0]   h_rdata_o,
  input  logic          h_lock_i,
  // TCM macro
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  owner_e     last_winner_q, last_winner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       resp_c_q, resp_h_q;
  logic       contended;
  logic       burst_open;
  logic       c_gnt, h_gnt;

  assign contended  = c_req_i & h_req_i;
  assign burst_open = (burst_cnt_q < MAX_CNT);

  // Winner selection; grants are held low while reset is asserted so that no
  // access reaches the TCM before the arbiter state is valid.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else tree can leave it unassigned and infer a latch.
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (rst_n) begin
      if (h_lock_i) begin
        h_gnt = h_req_i;
      end else if (contended) begin
        if (burst_open) begin
          h_gnt = (last_winner_q == OWNER_HOST);
        end else begin
          h_gnt = (last_winner_q == OWNER_CORE);
        end
        c_gnt = ~h_gnt;
      end else begin
        c_gnt = c_req_i;
        h_gnt = h_req_i;
      end
    end
  end

  // Next-state for the round-robin owner and its contended-run length.
  always_comb begin
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    if (c_gnt | h_gnt) begin
      last_winner_d = h_gnt ? OWNER_HOST : OWNER_CORE;
      // A locked, contended cycle is not a fair-share decision: the run length
      // is frozen so unlocking resumes where arbitration left off.
      if (!(h_lock_i && contended)) begin
        if (last_winner_d == last_winner_q) begin
          if (contended && burst_open) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else begin
          burst_cnt_d = contended ? 4'd1 : 4'd0;
        end
      end
    end
  end

  // Memory-side mux; idle cycles drive zeros so the macro sees a quiet bus.
  always_comb begin
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (h_gnt) begin
      mem_we_o    = h_be_i & {4{h_we_i}};
      mem_addr_o  = h_addr_i;
      mem_wdata_o = h_wdata_i;
    end else if (c_gnt) begin
      mem_we_o    = c_be_i & {4{c_we_i}};
      mem_addr_o  = c_addr_i;
      mem_wdata_o = c_wdata_i;
    end
  end

  // Arbiter state and response tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= OWNER_CORE;
      burst_cnt_q   <= 4'd0;
      resp_c_q      <= 1'b0;
      resp_h_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      resp_c_q      <= c_gnt;
      resp_h_q      <= h_gnt;
    end
  end

  assign c_gnt_o    = c_gnt;
  assign h_gnt_o    = h_gnt;
  assign mem_en_o   = c_gnt | h_gnt;
  assign c_rvalid_o = resp_c_q;
  assign h_rvalid_o = resp_h_q;
  assign c_rdata_o  = mem_rdata_i;
  assign h_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: a behavioural TCM macro answers the DUT, while a
// reference model (owner + streak counters, word array) predicts grants, the
// memory-side bus and every response.
`timescale 1ns/1ps
module tb_tcm_port_arbiter;
  localparam int AW = 15;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0, h_req = 1'b0, h_lock = 1'b0;
  logic          c_we = 1'b0, h_we = 1'b0;
  logic [3:0]    c_be = 4'h0, h_be = 4'h0;
  logic [AW-1:0] c_addr = '0, h_addr = '0;
  logic [31:0]   c_wdata = 32'h0, h_wdata = 32'h0;
  logic          c_gnt_o, h_gnt_o, c_rvalid_o, h_rvalid_o;
  logic [31:0]   c_rdata_o, h_rdata_o;
  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i = 32'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcm_port_arbiter #(.AW(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_i(c_req), .c_we_i(c_we), .c_be_i(c_be), .c_addr_i(c_addr),
    .c_wdata_i(c_wdata), .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o),
    .c_rdata_o(c_rdata_o),
    .h_req_i(h_req), .h_we_i(h_we), .h_be_i(h_be), .h_addr_i(h_addr),
    .h_wdata_i(h_wdata), .h_gnt_o(h_gnt_o), .h_rvalid_o(h_rvalid_o),
    .h_rdata_o(h_rdata_o), .h_lock_i(h_lock),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Behavioural single-port TCM with one-cycle read latency.
  logic [31:0] tcm [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) tcm[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata_i <= tcm[mem_addr_o];
    end
  end

  // Reference model state.
  int          m_owner;   // 0 = core, 1 = host
  int          m_streak;  // contended grants in the current run
  logic [31:0] ref_mem [0:63];
  bit          pend_c, pend_h, pend_rd;
  logic [31:0] pend_data;

  typedef struct {
    logic        cg, hg, men;
    logic [3:0]  mwe;
    logic        crv, hrv;
    logic [31:0] rdata;
  } obs_t;

  function automatic void model_reset();
    m_owner  = 0;
    m_streak = 0;
    pend_c   = 0;
    pend_h   = 0;
    pend_rd  = 0;
  endfunction

  // One arbitrated cycle: called just after a rising edge with inputs set.
  // Checks this cycle's grant/bus and the response to the previous grant.
  task automatic run_cycle(input bit cut_reset, output obs_t o);
    bit both, cg, hg, host_wins, rd;
    logic [3:0]    ewe;
    logic [AW-1:0] ea;
    logic [31:0]   ewd, got_rd;
    both = c_req && h_req;
    cg = 0; hg = 0;
    if (h_lock) hg = h_req;
    else if (both) begin
      host_wins = (m_streak < MB) ? (m_owner == 1) : (m_owner == 0);
      hg = host_wins;
      cg = !host_wins;
    end else begin
      cg = c_req;
      hg = h_req;
    end
    ewe = hg ? (h_be & {4{h_we}})  : (c_be & {4{c_we}});
    ea  = hg ? h_addr  : c_addr;
    ewd = hg ? h_wdata : c_wdata;
    rd  = hg ? !h_we   : !c_we;

    @(negedge clk);
    o.cg = c_gnt_o; o.hg = h_gnt_o; o.men = mem_en_o; o.mwe = mem_we_o;
    o.crv = c_rvalid_o; o.hrv = h_rvalid_o;
    o.rdata = c_rvalid_o ? c_rdata_o : h_rdata_o;

    total++;
    if ({c_gnt_o, h_gnt_o} !== {cg, hg}) begin
      bad++;
      $display("FAIL grant: got c=%b h=%b want c=%b h=%b (t=%0t)", c_gnt_o, h_gnt_o, cg, hg, $time);
    end
    total++;
    if (mem_en_o !== (cg | hg)) begin
      bad++;
      $display("FAIL mem_en: got %b want %b (t=%0t)", mem_en_o, cg | hg, $time);
    end
    total++;
    if (cg | hg) begin
      if (mem_we_o !== ewe || mem_addr_o !== ea || (|ewe && mem_wdata_o !== ewd)) begin
        bad++;
        $display("FAIL mem_bus: got we=%h a=%h d=%h want we=%h a=%h d=%h", mem_we_o, mem_addr_o,
                 mem_wdata_o, ewe, ea, ewd);
      end
    end else if (mem_we_o !== 4'h0) begin
      bad++;
      $display("FAIL mem_we_idle: got %h want 0", mem_we_o);
    end
    total++;
    if ({c_rvalid_o, h_rvalid_o} !== {pend_c, pend_h}) begin
      bad++;
      $display("FAIL rvalid: got c=%b h=%b want c=%b h=%b (t=%0t)", c_rvalid_o, h_rvalid_o,
               pend_c, pend_h, $time);
    end
    if ((pend_c || pend_h) && pend_rd) begin
      got_rd = pend_c ? c_rdata_o : h_rdata_o;
      total++;
      if (got_rd !== pend_data) begin
        bad++;
        $display("FAIL rdata: got %h want %h (t=%0t)", got_rd, pend_data, $time);
      end
    end

    pend_c = cg; pend_h = hg; pend_rd = 0;
    if (cg || hg) begin
      pend_rd   = rd;
      pend_data = ref_mem[ea[5:0]];
      for (int b = 0; b < 4; b++)
        if (ewe[b]) ref_mem[ea[5:0]][8*b +: 8] = ewd[8*b +: 8];
      if (!(h_lock && both)) begin
        if ((hg ? 1 : 0) == m_owner) begin
          if (both && m_streak < MB) m_streak++;
        end else begin
          m_streak = both ? 1 : 0;
        end
      end
      m_owner = hg ? 1 : 0;
    end
    if (cut_reset) begin
      rst_n = 1'b0;
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic new_core_tx();
    c_req = 1'b1; c_we = 1'($urandom_range(1)); c_be = 4'($urandom_range(15));
    c_addr = AW'($urandom_range(31)); c_wdata = $urandom();
  endtask

  task automatic new_host_tx();
    h_req = 1'b1; h_we = 1'($urandom_range(1)); h_be = 4'($urandom_range(15));
    h_addr = AW'($urandom_range(31)); h_wdata = $urandom();
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'(3);
    h_req = 1'b1; h_we = 1'b0; h_addr = AW'(4);
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({c_gnt_o, h_gnt_o, c_rvalid_o, h_rvalid_o, mem_en_o} !== 5'b0 ||
          mem_we_o !== 4'h0 || mem_addr_o !== '0 || mem_wdata_o !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b en=%b we=%h a=%h d=%h want all 0",
                 c_gnt_o, h_gnt_o, c_rvalid_o, h_rvalid_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_cycle(0, o);
    total++;
    if (o.cg !== 1'b1 || o.hg !== 1'b0) begin
      bad++;
      $display("FAIL first_grant: got c=%b h=%b want c=1 h=0", o.cg, o.hg);
    end
  endtask

  task automatic test_host_write_read();
    obs_t o;
    c_req = 1'b0;
    h_req = 1'b1; h_we = 1'b1; h_be = 4'hF; h_addr = AW'(16'h0010); h_wdata = 32'hDEADBEEF;
    run_cycle(0, o);
    total++;
    if (o.mwe !== 4'hF) begin
      bad++;
      $display("FAIL host_write_we: got %h want f", o.mwe);
    end
    h_we = 1'b0;
    run_cycle(0, o);
    h_req = 1'b0;
    run_cycle(0, o);
    total++;
    if (o.hrv !== 1'b1 || o.crv !== 1'b0 || o.rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL host_readback: got hrv=%b crv=%b data=%h want 1 0 deadbeef", o.hrv, o.crv, o.rdata);
    end
  endtask

  task automatic test_partial_write();
    obs_t o;
    h_req = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_be = 4'hF; c_addr = AW'(16'h0020); c_wdata = 32'h11223344;
    run_cycle(0, o);
    c_be = 4'b0011; c_wdata = 32'hAAAABBBB;
    run_cycle(0, o);
    c_we = 1'b0;
    run_cycle(0, o);
    c_req = 1'b0;
    run_cycle(0, o);
    total++;
    if (o.crv !== 1'b1 || o.rdata !== 32'h1122BBBB) begin
      bad++;
      $display("FAIL partial_write: got crv=%b data=%h want 1 1122bbbb", o.crv, o.rdata);
    end
  endtask

  task automatic test_contention();
    obs_t o;
    bit exp_h;
    apply_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'(1);
    h_req = 1'b1; h_we = 1'b0; h_addr = AW'(2);
    for (int i = 0; i < 16; i++) begin
      exp_h = ((i / MB) % 2) == 1;
      run_cycle(0, o);
      total++;
      if (o.hg !== exp_h || o.cg !== !exp_h) begin
        bad++;
        $display("FAIL burst_seq[%0d]: got c=%b h=%b want c=%b h=%b", i, o.cg, o.hg, !exp_h, exp_h);
      end
      if (o.cg) c_addr = AW'($urandom_range(31));
      if (o.hg) h_addr = AW'($urandom_range(31));
    end
  endtask

  task automatic test_reset_midop();
    obs_t o;
    bit exp_h;
    // Host just finished a full run, so the contended core read wins here.
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'(5);
    h_req = 1'b1; h_we = 1'b0;
    run_cycle(1, o);
    total++;
    if (o.cg !== 1'b1) begin
      bad++;
      $display("FAIL midop_grant: got c=%b want 1", o.cg);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (c_rvalid_o !== 1'b0 || h_rvalid_o !== 1'b0) begin
        bad++;
        $display("FAIL midop_rvalid: got c=%b h=%b want 0 0", c_rvalid_o, h_rvalid_o);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i <= MB; i++) begin
      exp_h = (i == MB);
      run_cycle(0, o);
      total++;
      if (o.hg !== exp_h || o.cg !== !exp_h) begin
        bad++;
        $display("FAIL post_reset_seq[%0d]: got c=%b h=%b want c=%b h=%b", i, o.cg, o.hg, !exp_h, exp_h);
      end
    end
  endtask

  task automatic test_lock();
    obs_t o;
    apply_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'(7);
    h_req = 1'b1; h_we = 1'b0; h_addr = AW'(8);
    run_cycle(0, o);
    c_addr = AW'(9);
    h_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_cycle(0, o);
      if (i == 0) begin
        total++;
        if (o.crv !== 1'b1) begin
          bad++;
          $display("FAIL lock_keeps_core_rvalid: got %b want 1", o.crv);
        end
      end
      total++;
      if (o.hg !== 1'b1 || o.cg !== 1'b0) begin
        bad++;
        $display("FAIL locked_grant[%0d]: got c=%b h=%b want c=0 h=1", i, o.cg, o.hg);
      end
      new_host_tx();
    end
    h_lock = 1'b0;
    repeat (6) begin
      run_cycle(0, o);
      if (o.cg) new_core_tx();
      if (o.hg) new_host_tx();
    end
  endtask

  task automatic test_random();
    obs_t o;
    h_lock = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!c_req && $urandom_range(9) < 6) new_core_tx();
      if (!h_req && $urandom_range(9) < 6) new_host_tx();
      if ($urandom_range(19) == 0) h_lock = !h_lock;
      run_cycle(0, o);
      if (o.cg) c_req = 1'b0;
      if (o.hg) h_req = 1'b0;
    end
    h_lock = 1'b0; c_req = 1'b0; h_req = 1'b0;
    run_cycle(0, o);
  endtask

  initial begin
    obs_t o;
    for (int i = 0; i < (1 << AW); i++) tcm[i] = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    model_reset();
    #1;
    test_reset();
    test_host_write_read();
    test_partial_write();
    test_contention();
    test_reset_midop();
    test_lock();
    test_random();
    c_req = 1'b0; h_req = 1'b0;
    run_cycle(0, o);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Arbiter that shares the single-port TCM between the core data port and a host port (boot loader / signature readback) so that program images can be loaded and compliance signatures read out over hardware instead of backdoor memory tasks. It sits between the two requesters and the TCM macro, issues at most one access per cycle, and routes the one-cycle-latency responses back to the owner. The arbitration policy is bounded-burst round-robin, and a host lock gives the loader exclusive access.

## Interface
- AW, 15, word address width (32 KiW = 128 KiB TCM)
- MAX_BURST, 4, max consecutive contended grants to one requester (1..15)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c_req_i / h_req_i  in  1  core / host request
- c_we_i / h_we_i  in  1  1 = write, 0 = read
- c_be_i / h_be_i  in  4  byte enables (writes only)
- c_addr_i / h_addr_i  in  AW  word address
- c_wdata_i / h_wdata_i  in  32  write data
- c_gnt_o / h_gnt_o  out  1  request accepted this cycle (combinational)
- c_rvalid_o / h_rvalid_o  out  1  response for the access granted last cycle
- c_rdata_o / h_rdata_o  out  32  read data, valid with rvalid on reads
- h_lock_i  in  1  host exclusive mode: core is never granted
- mem_en_o  out  1  TCM access strobe
- mem_we_o  out  4  TCM byte write enables (0 on reads)
- mem_addr_o  out  AW  TCM address
- mem_wdata_o  out  32  TCM write data
- mem_rdata_i  in  32  TCM read data, one cycle after mem_en_o

## Operation
- Requests are held until granted. The requester must keep req, addr, we, be and wdata stable while req=1 and gnt=0.
- Winner selection, evaluated every cycle:
  - h_lock_i=1: host wins if h_req_i; c_gnt_o=0 regardless of c_req_i.
  - Exactly one requester: it wins.
  - Both requesting (contended): last_winner wins if burst_cnt < MAX_BURST, else the other requester wins.
- State:
  - last_winner: 1 bit, reset = core; updated on every grant.
  - burst_cnt: 4 bits, reset = 0.
    - Grant to last_winner while contended: burst_cnt increments, saturating at MAX_BURST.
    - Grant that changes the winner: burst_cnt is set to 1 if contended, else 0.
    - Uncontended grant to last_winner: burst_cnt is unchanged.
    - Contended arbitration while h_lock_i=1: burst_cnt is unchanged.
- Memory side:
  - mem_en_o = c_gnt_o | h_gnt_o.
  - mem_addr_o, mem_wdata_o and mem_we_o (= be & {4{we}}) are muxed from the winner.
  - When idle, mem_we_o=0; mem_addr_o and mem_wdata_o are don't-care.
- Response path:
  - Registers resp_c and resp_h are set on the cycle of a grant (both reads and writes) and produce rvalid exactly one cycle later.
  - c_rdata_o = h_rdata_o = mem_rdata_i. Data is meaningful only with rvalid on a read.
  - The two rvalid outputs are mutually exclusive.
- Lock transitions:
  - Asserting h_lock_i does not cancel a core access granted the previous cycle; its rvalid is still delivered.
  - Deasserting h_lock_i restores normal arbitration the same cycle.

## Timing
- Grant: combinational, same cycle as req. Back-to-back accesses are allowed, one per cycle, full throughput.
- Latency: gnt at cycle N, mem_en_o at cycle N, rvalid/rdata at cycle N+1.
- Reset values:
  - All gnt, rvalid, mem_en_o: 0.
  - mem_we_o: 0.
  - resp_c, resp_h: 0.
  - last_winner: core.
  - burst_cnt: 0.
- Reset mid-operation: any pending response is dropped (no rvalid after reset). The first cycle after rst_n rises is arbitrated normally.
- Sustained contention with MAX_BURST=M: grants alternate in runs of M per requester. Neither side waits more than M cycles.

## Test plan
- Reset with c_req_i=h_req_i=1 held high -> all outputs 0 during reset. After release, core is granted first (last_winner=core, cnt=0).
- Host writes 0xDEADBEEF, be=4'hF, to addr 0x0010, then reads 0x0010 -> mem_we_o=4'hF at cycle N. At N+2, h_rvalid_o=1 with h_rdata_o=0xDEADBEEF; c_rvalid_o stays 0.
- Both requesters request continuously for 16 cycles, MAX_BURST=4 -> grant sequence C,C,C,C,H,H,H,H repeated twice. Exactly one gnt per cycle.
- Core granted at cycle N, h_lock_i rises at N+1 with both requesting -> c_rvalid_o=1 at N+1. Host granted at every cycle from N+1 while locked; c_gnt_o=0 throughout.
- Partial write: be=4'b0011 on a word holding 0x11223344 with wdata=0xAAAABBBB -> a subsequent read returns 0x1122BBBB.
- rst_n asserted the cycle after a core read grant -> no c_rvalid_o pulse. After release, state matches the reset values.
